seg7_scan_ctrl: RTL and testbench

- Wishbone-configurable scan controller for the 4-digit multiplexed 7-segment display on user IO 7..18 (digit enables 7..10, segments a-g+dp 11..18).
- Time-multiplexes four segment bytes onto the shared segment bus.
- Inserts a blanking guard between digits for anti-ghosting.
- Applies PWM brightness and double-buffers display data so that frames never tear.
- Sits directly under user_project_wrapper and drives the 12 display pads.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_tick_gen.sv | 18 +
 rtl/seg7_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: register map, CTRL fields, scan states and sizing for the 7-segment scan controller
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int SLOT_BITS  = 8;
    localparam logic [3:0] OFF_DATA     = 4'h0;
    localparam logic [3:0] OFF_CTRL     = 4'h4;
    localparam logic [3:0] OFF_PRESCALE = 4'h8;
    localparam logic [3:0] OFF_STATUS   = 4'hC;
    localparam int CTRL_EN         = 0;
    localparam int CTRL_POL        = 1;
    localparam int CTRL_BRIGHT_LSB = 8;
    typedef enum logic {S_OFF, S_SCAN} scan_state_e;
    function automatic logic [31:0] apply_sel(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sel[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction
endpackage

// File: rtl/seg7_tick_gen.sv
// seg7_tick_gen: prescaler emitting a one-cycle tick every prescale+1 clocks, with synchronous clear
module seg7_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] prescale,
    input  logic        clr,
    output logic        tick
);
    logic [15:0] cnt_q, cnt_d;
    always_comb begin
        tick  = ~clr & (cnt_q == prescale);
        cnt_d = (clr | tick) ? 16'd0 : cnt_q + 16'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: Wishbone-configured 4-digit multiplexed 7-segment scanner with PWM and frame-latched data
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [15:0] PRESCALE_RST = 16'd99
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  digit_en_o,
    output logic [7:0]  seg_o,
    output logic [11:0] io_oeb_o
);
    localparam int DIG_BITS = $clog2(NUM_DIGITS);
    scan_state_e state_q, state_d;
    logic [31:0] data_q, data_d, shadow_q, shadow_d, dat_q, dat_d, rdata;
    logic en_q, en_d, pol_q, pol_d, ack_q, ack_d;
    logic [7:0] bright_q, bright_d, seg_q, seg_d;
    logic [15:0] prescale_q, prescale_d;
    logic [SLOT_BITS-1:0] slot_q, slot_d;
    logic [DIG_BITS-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0] den_q, den_d;
    logic [3:0] off;
    logic hit, acc, wr, wr_ctrl, wr_pre, tick, on;
    seg7_tick_gen u_tick (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .prescale (prescale_q),
        .clr      ((state_q == S_OFF) | wr_pre),
        .tick     (tick)
    );
    always_comb begin
        off     = wbs_adr_i[3:0];
        hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        acc     = hit & ~ack_q;
        wr      = acc & wbs_we_i;
        wr_ctrl = wr && off == OFF_CTRL;
        wr_pre  = wr && off == OFF_PRESCALE;
        rdata   = off == OFF_DATA     ? data_q :
                  off == OFF_CTRL     ? {16'd0, bright_q, 6'd0, pol_q, en_q} :
                  off == OFF_PRESCALE ? {16'd0, prescale_q} :
                  off == OFF_STATUS   ? {16'd0, slot_q, 6'd0, digit_q} : 32'd0;
        ack_d      = acc;
        dat_d      = (acc & ~wbs_we_i) ? rdata : 32'd0;
        data_d     = (wr && off == OFF_DATA) ? apply_sel(data_q, wbs_dat_i, wbs_sel_i) : data_q;
        en_d       = (wr_ctrl & wbs_sel_i[0]) ? wbs_dat_i[CTRL_EN] : en_q;
        pol_d      = (wr_ctrl & wbs_sel_i[0]) ? wbs_dat_i[CTRL_POL] : pol_q;
        bright_d   = (wr_ctrl & wbs_sel_i[1]) ? wbs_dat_i[CTRL_BRIGHT_LSB +: 8] : bright_q;
        prescale_d = {(wr_pre & wbs_sel_i[1]) ? wbs_dat_i[15:8] : prescale_q[15:8],
                      (wr_pre & wbs_sel_i[0]) ? wbs_dat_i[7:0]  : prescale_q[7:0]};
        state_d  = state_q;
        slot_d   = slot_q;
        digit_d  = digit_q;
        shadow_d = shadow_q;
        if (state_q == S_OFF) begin
            slot_d  = '0;
            digit_d = '0;
            if (en_q) begin
                state_d  = S_SCAN;
                shadow_d = data_q;
            end
        end else if (!en_q) begin
            state_d = S_OFF;
            slot_d  = '0;
            digit_d = '0;
        end else if (tick) begin
            slot_d = slot_q + 1'b1;
            if (slot_q == '1) begin
                digit_d = digit_q + 1'b1;
                // shadow only reloads at the frame boundary so a frame never mixes old and new data
                if (digit_q == DIG_BITS'(NUM_DIGITS - 1)) shadow_d = data_q;
            end
        end
        on    = (state_q == S_SCAN) && (slot_q < bright_q);
        den_d = (on ? NUM_DIGITS'(1) << digit_q : '0) ^ {NUM_DIGITS{pol_q}};
        seg_d = (on ? shadow_q[{digit_q, 3'b000} +: 8] : 8'd0) ^ {8{pol_q}};
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_OFF;
            data_q     <= '0;
            shadow_q   <= '0;
            dat_q      <= '0;
            en_q       <= 1'b0;
            pol_q      <= 1'b0;
            ack_q      <= 1'b0;
            bright_q   <= '0;
            seg_q      <= '0;
            prescale_q <= PRESCALE_RST;
            slot_q     <= '0;
            digit_q    <= '0;
            den_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shadow_q   <= shadow_d;
            dat_q      <= dat_d;
            en_q       <= en_d;
            pol_q      <= pol_d;
            ack_q      <= ack_d;
            bright_q   <= bright_d;
            seg_q      <= seg_d;
            prescale_q <= prescale_d;
            slot_q     <= slot_d;
            digit_q    <= digit_d;
            den_q      <= den_d;
        end
    end
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign digit_en_o = den_q;
    assign seg_o      = seg_q;
    assign io_oeb_o   = 12'd0;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for the 7-segment scan controller
module tb_seg7_scan_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [3:0]  den;
    logic [7:0]  seg;
    logic [11:0] oeb;
    int n_run = 0, n_fail = 0;
    string tag_q[$];
    logic [31:0] exp_q[$];
    logic [7:0] eb[4];
    int lit[4];
    int bad;
    always #5 clk = ~clk;
    seg7_scan_ctrl dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .digit_en_o(den), .seg_o(seg), .io_oeb_o(oeb)
    );
    task automatic expect_val(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask
    task automatic check(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        n_run++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rv, output logic got);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        got = 0; rv = '0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; rv = rdat; end
        end
        cyc = 0; stb = 0; we = 0;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] rv;
        logic got;
        expect_val("wr_ack", 32'd1);
        wb(1'b1, a, d, s, rv, got);
        check({31'd0, got});
    endtask
    task automatic rd(input string t, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] rv;
        logic got;
        expect_val(t, e);
        wb(1'b0, a, 32'd0, 4'hF, rv, got);
        check(got ? rv : 32'bx);
    endtask
    function automatic int idx(input logic [3:0] v);
        return v == 4'b0001 ? 0 : v == 4'b0010 ? 1 : v == 4'b0100 ? 2 : v == 4'b1000 ? 3 : -1;
    endfunction
    task automatic scan(input int n);
        int i;
        lit = '{default: 0};
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            i = idx(den);
            if (i >= 0) begin
                lit[i]++;
                if (seg !== eb[i]) bad++;
            end else if (den !== 4'h0 || seg !== 8'h00) bad++;
        end
    endtask
    initial begin
        logic [31:0] rv;
        logic got, found, prev;
        int na, cons, seen, i;
        eb = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
        @(negedge clk);
        expect_val("rst_den", 0);  check({28'd0, den});
        expect_val("rst_seg", 0);  check({24'd0, seg});
        expect_val("rst_ack", 0);  check({31'd0, ack});
        expect_val("rst_dat", 0);  check(rdat);
        expect_val("oeb", 0);      check({20'd0, oeb});
        rst = 0;
        rd("rst_prescale", BASE + 32'h8, 32'd99);
        rd("rst_ctrl", BASE + 32'h4, 32'd0);
        rd("rst_status", BASE + 32'hC, 32'd0);
        rd("rst_data", BASE, 32'd0);
        wr(BASE, 32'h4F5B_063F);
        rd("data_rb", BASE, 32'h4F5B_063F);
        wr(BASE, 32'hAABB_CCDD, 4'b0010);
        rd("sel_lane", BASE, 32'h4F5B_CC3F);
        wr(BASE, 32'h4F5B_063F);
        expect_val("oob_noack", 0);
        wb(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, rv, got);
        check({31'd0, got});
        wr(BASE + 32'hC, 32'h0000_FFFF);
        rd("status_ro", BASE + 32'hC, 32'd0);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h8; sel = 4'hF;
        na = 0; cons = 0; prev = 0; bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack) begin
                na++;
                if (rdat !== 32'd99) bad++;
            end
            if (ack && prev) cons++;
            prev = ack;
        end
        cyc = 0; stb = 0;
        expect_val("burst_acks", 3);    check(na);
        expect_val("burst_consec", 0);  check(cons);
        expect_val("burst_data", 0);    check(bad);
        wr(BASE + 32'h8, 32'd0);
        rd("prescale_rb", BASE + 32'h8, 32'd0);
        wr(BASE + 32'h4, 32'h0000_FF01);
        rd("ctrl_rb", BASE + 32'h4, 32'h0000_FF01);
        repeat (16) @(negedge clk);
        scan(2048);
        for (int k = 0; k < 4; k++) begin
            expect_val($sformatf("lit_full_d%0d", k), 510);
            check(lit[k]);
        end
        expect_val("full_seg_bad", 0); check(bad);
        found = 0;
        for (int k = 0; k < 1100 && !found; k++) begin
            @(negedge clk);
            if (den === 4'b0010) found = 1;
        end
        expect_val("wait_digit1", 1); check({31'd0, found});
        wr(BASE, 32'hFFFF_FFFF);
        found = 0; bad = 0; seen = 0;
        for (int k = 0; k < 1100 && !found; k++) begin
            @(negedge clk);
            i = idx(den);
            if (i == 0) found = 1;
            else if (i > 0) begin
                seen++;
                if (seg !== eb[i]) bad++;
            end
        end
        expect_val("latch_found_d0", 1); check({31'd0, found});
        expect_val("latch_old_bytes", 0); check(bad);
        expect_val("latch_seen", 1);      check({31'd0, seen >= 510});
        expect_val("latch_new_d0", 8'hFF); check({24'd0, seg});
        eb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wr(BASE + 32'h4, 32'h0000_4001);
        repeat (16) @(negedge clk);
        scan(1024);
        for (int k = 0; k < 4; k++) begin
            expect_val($sformatf("lit_pwm_d%0d", k), 64);
            check(lit[k]);
        end
        expect_val("pwm_seg_bad", 0); check(bad);
        wr(BASE + 32'h4, 32'h0000_0001);
        repeat (4) @(negedge clk);
        scan(300);
        expect_val("bright0_lit", 0); check(lit[0] + lit[1] + lit[2] + lit[3]);
        wr(BASE + 32'h4, 32'h0000_0002);
        repeat (3) @(negedge clk);
        expect_val("pol_off_den", 4'hF); check({28'd0, den});
        expect_val("pol_off_seg", 8'hFF); check({24'd0, seg});
        wr(BASE, 32'h4F5B_063F);
        wr(BASE + 32'h4, 32'h0000_FF03);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (den !== 4'hF) found = 1;
        end
        expect_val("pol_on_found", 1); check({31'd0, found});
        expect_val("pol_on_den", 4'hE); check({28'd0, den});
        expect_val("pol_on_seg", 8'hC0); check({24'd0, seg});
        repeat (37) @(negedge clk);
        @(posedge clk); #3;
        rst = 1;
        #1;
        expect_val("async_rst_den", 0); check({28'd0, den});
        expect_val("async_rst_seg", 0); check({24'd0, seg});
        expect_val("async_rst_ack", 0); check({31'd0, ack});
        #2;
        rst = 0;
        rd("post_rst_status", BASE + 32'hC, 32'd0);
        rd("post_rst_prescale", BASE + 32'h8, 32'd99);
        rd("post_rst_ctrl", BASE + 32'h4, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
